// File: rtl/adex_param_loader_tx_if.sv
// adex_param_loader_tx_if: host command and nibble-serial receiver signals for the AdEx parameter loader
interface adex_param_loader_tx_if;
  logic        start_i;
  logic        abort_i;
  logic [63:0] params_i;
  logic        ready_i;
  logic        load_mode_o;
  logic        load_enable_o;
  logic [3:0]  nibble_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  modport slave (
    input  start_i, abort_i, params_i, ready_i,
    output load_mode_o, load_enable_o, nibble_o, busy_o, done_o, err_o
  );
  modport master (
    output start_i, abort_i, params_i, ready_i,
    input  load_mode_o, load_enable_o, nibble_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/adex_param_loader_tx.sv
// adex_param_loader_tx: sends eight parameter bytes as arm edge, 16 nibbles and 0xF footer, then awaits ready
module adex_param_loader_tx #(
  parameter int LOW_CYC       = 2,
  parameter int HIGH_CYC      = 2,
  parameter int READY_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  adex_param_loader_tx_if.slave bus
);
  localparam int M1 = (LOW_CYC > HIGH_CYC) ? LOW_CYC : HIGH_CYC;
  localparam int M2 = (M1 > READY_TIMEOUT) ? M1 : READY_TIMEOUT;
  localparam int CW = $clog2(M2 + 1);
  localparam logic [CW-1:0] LO_END = CW'(LOW_CYC - 1);
  localparam logic [CW-1:0] HI_END = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] RT_END = CW'(READY_TIMEOUT - 1);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GAP      = 3'd1;
  localparam logic [2:0] SLOT_LO  = 3'd2;
  localparam logic [2:0] SLOT_HI  = 3'd3;
  localparam logic [2:0] WAIT_RDY = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [4:0]    s_q, s_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [63:0]   p_q, p_d;
  logic [3:0]    nib_q, nib_d, slot_nib, k;
  logic          done_q, done_d, err_q, err_d;

  // slot s carries nibble k=s-1; nibble index k^1 puts each byte's high nibble first
  assign k        = 4'(s_d - 5'd1);
  assign slot_nib = (s_d == 5'd0) ? 4'h0 : (s_d == 5'd17) ? 4'hF : p_q[{k ^ 4'd1, 2'b00} +: 4];

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    p_d     = p_q;
    err_d   = err_q;
    cyc_d   = (state_q inside {GAP, SLOT_LO, SLOT_HI, WAIT_RDY}) ? cyc_q + CW'(1) : '0;
    case (state_q)
      IDLE, DONE: if (bus.start_i) begin
        state_d = GAP;
        p_d     = bus.params_i;
        err_d   = 1'b0;
      end
      GAP: if (cyc_q == CW'(1)) begin
        state_d = SLOT_LO;
        s_d     = 5'd0;
        cyc_d   = '0;
      end
      SLOT_LO: if (cyc_q == LO_END) begin
        state_d = SLOT_HI;
        cyc_d   = '0;
      end
      SLOT_HI: if (cyc_q == HI_END) begin
        state_d = (s_q == 5'd17) ? WAIT_RDY : SLOT_LO;
        s_d     = s_q + 5'd1;
        cyc_d   = '0;
      end
      WAIT_RDY: if (READY_TIMEOUT == 0 || bus.ready_i) state_d = DONE;
        else if (cyc_q == RT_END) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      default: state_d = IDLE;
    endcase
    if (bus.abort_i) begin
      state_d = IDLE;
      p_d     = p_q;
      err_d   = err_q;
    end
    done_d = (state_d == DONE) && (state_q != DONE);
    nib_d  = (state_d == SLOT_LO && state_q != SLOT_LO) ? slot_nib :
             (state_d == IDLE || state_d == GAP) ? 4'h0 : nib_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      cyc_q   <= '0;
      p_q     <= '0;
      nib_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cyc_q   <= cyc_d;
      p_q     <= p_d;
      nib_q   <= nib_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.load_mode_o   = state_q inside {SLOT_LO, SLOT_HI, WAIT_RDY, DONE};
  assign bus.load_enable_o = state_q == SLOT_HI;
  assign bus.busy_o        = state_q inside {GAP, SLOT_LO, SLOT_HI, WAIT_RDY};
  assign bus.nibble_o      = nib_q;
  assign bus.done_o        = done_q;
  assign bus.err_o         = err_q;
endmodule

// File: tb/tb_adex_param_loader_tx.sv
// tb_adex_param_loader_tx: directed checks of slot timing, nibble order, ready/timeout, abort and reset
module tb_adex_param_loader_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  adex_param_loader_tx_if ia();
  adex_param_loader_tx_if ib();
  adex_param_loader_tx_if ic();

  adex_param_loader_tx dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  adex_param_loader_tx #(.LOW_CYC(1), .HIGH_CYC(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  adex_param_loader_tx #(.READY_TIMEOUT(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

  always #5 clk = ~clk;

  // receiver models: capture a nibble per load_enable rise, raise ready after the footer
  logic [71:0] sh_a = '0, sh_b = '0;
  int ca = 0, cb = 0, dn_a = 0;
  logic pe_a = 0, pe_b = 0, rdy_a = 0, rdy_b = 0, ren_a = 0, ren_b = 0;
  assign ia.ready_i = rdy_a;
  assign ib.ready_i = rdy_b;
  assign ic.ready_i = 1'b0;

  always @(negedge clk) begin
    if (!ia.load_mode_o) begin
      ca <= 0;
      rdy_a <= 1'b0;
    end else if (ia.load_enable_o && !pe_a) begin
      sh_a <= {sh_a[67:0], ia.nibble_o};
      ca <= ca + 1;
      if (ca == 17 && ren_a) rdy_a <= 1'b1;
    end
    pe_a <= ia.load_enable_o;
    if (ia.done_o) dn_a <= dn_a + 1;
    if (!ib.load_mode_o) begin
      cb <= 0;
      rdy_b <= 1'b0;
    end else if (ib.load_enable_o && !pe_b) begin
      sh_b <= {sh_b[67:0], ib.nibble_o};
      cb <= cb + 1;
      if (cb == 17 && ren_b) rdy_b <= 1'b1;
    end
    pe_b <= ib.load_enable_o;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] outs_a();
    return {ia.load_mode_o, ia.load_enable_o, ia.nibble_o, ia.busy_o, ia.done_o, ia.err_o};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    {ia.start_i, ia.abort_i, ia.params_i} = '0;
    {ib.start_i, ib.abort_i, ib.params_i} = '0;
    {ic.start_i, ic.abort_i, ic.params_i} = '0;
    tick(3);
    chk("reset_outs_a", outs_a(), 9'h0);
    chk("reset_outs_b", {ib.load_mode_o, ib.busy_o, ib.done_o, ib.err_o}, 4'h0);
    rst_n = 1'b1;
    tick(1);
    // normal load, defaults
    ia.params_i = 64'h0A_B4_4E_3F_05_01_64_82;
    ren_a = 1'b1;
    ia.start_i = 1'b1;
    tick(1);
    ia.start_i = 1'b0;
    chk("t1_gap", {ia.busy_o, ia.load_mode_o}, 2'b10);
    tick(2);
    chk("t1_slot0_lo", {ia.load_mode_o, ia.load_enable_o, ia.nibble_o}, 6'b10_0000);
    tick(2);
    chk("t1_slot0_rise", ia.load_enable_o, 1'b1);
    tick(2);
    chk("t1_slot1_lo", {ia.load_enable_o, ia.nibble_o}, 5'b0_1000);
    tick(68);
    chk("t1_wait", {ia.load_mode_o, ia.load_enable_o, ia.nibble_o, ia.busy_o, ia.done_o}, 8'b10_1111_10);
    tick(1);
    chk("t1_done", {ia.done_o, ia.busy_o, ia.load_mode_o}, 3'b101);
    chk("t1_nibbles", sh_a, 72'h0_8264_0105_3F4E_B40A_F);
    chk("t1_count", 72'(ca), 72'd18);
    tick(1);
    chk("t1_done_pulse", {ia.done_o, ia.load_mode_o}, 2'b01);
    // ready timeout, restarted from DONE
    ia.params_i = 64'h11_22_33_44_55_66_77_88;
    ren_a = 1'b0;
    ia.start_i = 1'b1;
    tick(1);
    ia.start_i = 1'b0;
    chk("t2_restart_gap", {ia.load_mode_o, ia.busy_o, ia.done_o}, 3'b010);
    tick(74);
    chk("t2_wait", {ia.load_mode_o, ia.busy_o, ia.nibble_o}, 6'b11_1111);
    tick(63);
    chk("t2_wait_last", {ia.load_mode_o, ia.busy_o, ia.err_o}, 3'b110);
    tick(1);
    chk("t2_timeout", outs_a(), 9'b0_0_0000_0_0_1);
    chk("t2_nibbles", sh_a, 72'h0_8877_6655_4433_2211_F);
    chk("t2_no_done", 72'(dn_a), 72'd1);
    // abort during slot 7, then a clean reload
    ia.params_i = 64'h01_23_45_67_89_AB_CD_EF;
    ren_a = 1'b1;
    ia.start_i = 1'b1;
    tick(1);
    ia.start_i = 1'b0;
    chk("t3_err_clear", {ia.err_o, ia.busy_o}, 2'b01);
    tick(31);
    chk("t3_slot7", {ia.load_mode_o, ia.load_enable_o, ia.nibble_o}, 6'b10_1000);
    ia.abort_i = 1'b1;
    tick(1);
    ia.abort_i = 1'b0;
    chk("t3_abort", outs_a(), 9'h0);
    tick(1);
    chk("t3_model_idle", 72'(ca), 72'd0);
    ia.start_i = 1'b1;
    tick(1);
    ia.start_i = 1'b0;
    tick(75);
    chk("t3_reload_done", {ia.done_o, ia.err_o}, 2'b10);
    chk("t3_nibbles", sh_a, 72'h0_EFCD_AB89_6745_2301_F);
    // abort beats start while in DONE
    ia.start_i = 1'b1;
    ia.abort_i = 1'b1;
    tick(1);
    ia.start_i = 1'b0;
    ia.abort_i = 1'b0;
    chk("t3_abort_wins", outs_a(), 9'h0);
    tick(1);
    chk("t3_start_ignored", outs_a(), 9'h0);
    // reset during slot 12
    ia.start_i = 1'b1;
    tick(1);
    ia.start_i = 1'b0;
    tick(51);
    chk("t4_slot12", {ia.load_mode_o, ia.busy_o}, 2'b11);
    rst_n = 1'b0;
    tick(1);
    chk("t4_reset_outs", outs_a(), 9'h0);
    rst_n = 1'b1;
    tick(1);
    // LOW_CYC = HIGH_CYC = 1
    ib.params_i = 64'h01_23_45_67_89_AB_CD_EF;
    ren_b = 1'b1;
    ib.start_i = 1'b1;
    tick(1);
    ib.start_i = 1'b0;
    chk("t5_gap", {ib.busy_o, ib.load_mode_o}, 2'b10);
    tick(3);
    chk("t5_rise0", {ib.load_mode_o, ib.load_enable_o}, 2'b11);
    tick(1);
    chk("t5_low1", ib.load_enable_o, 1'b0);
    tick(1);
    chk("t5_rise1", {ib.load_enable_o, ib.nibble_o}, 5'b1_1110);
    tick(33);
    chk("t5_wait", {ib.load_mode_o, ib.load_enable_o, ib.nibble_o, ib.busy_o, ib.done_o}, 8'b10_1111_10);
    tick(1);
    chk("t5_done", {ib.done_o, ib.busy_o}, 2'b10);
    chk("t5_nibbles", sh_b, 72'h0_EFCD_AB89_6745_2301_F);
    ib.params_i = 64'h0A_B4_4E_3F_05_01_64_82;
    ib.start_i = 1'b1;
    tick(1);
    ib.start_i = 1'b0;
    chk("t5_restart_gap1", {ib.load_mode_o, ib.busy_o}, 2'b01);
    tick(1);
    chk("t5_restart_gap2", ib.load_mode_o, 1'b0);
    tick(1);
    chk("t5_restart_slot0", ib.load_mode_o, 1'b1);
    tick(37);
    chk("t5_reload_done", ib.done_o, 1'b1);
    chk("t5_reload_nibbles", sh_b, 72'h0_8264_0105_3F4E_B40A_F);
    // READY_TIMEOUT = 0 with ready held low
    ic.params_i = 64'h0A_B4_4E_3F_05_01_64_82;
    ic.start_i = 1'b1;
    tick(1);
    ic.start_i = 1'b0;
    tick(74);
    chk("t6_wait", {ic.load_mode_o, ic.busy_o, ic.done_o}, 3'b110);
    tick(1);
    chk("t6_done", {ic.done_o, ic.busy_o, ic.err_o, ic.load_mode_o}, 4'b1001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
